// File: rtl/run_seq_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding, datapath widths
// and a small address helper used by the load and result phases.
package run_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KICK = 3'd2,
    RUN  = 3'd3,
    READ = 3'd4,
    SEND = 3'd5
  } seqState_e;

  // DMem addresses are 8 bits wide and wrap 255 -> 0.
  function automatic logic [ADDR_W-1:0] addrInc(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/run_sequencer_watchdog.sv
// run_watchdog: cycle counter guarding the RUN phase. Clear has priority over
// Enable; Expired rises on the TIMEOUT_CYC-th enabled cycle after a clear and
// the count then holds until the next clear.
module run_watchdog #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count enabled cycles up to the terminal value.
  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (Enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Expired = Enable && (count_q == LAST);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: host front end for the CPU core. Loads a byte image into DMem,
// kicks the core with Start, waits for Done under a watchdog, then streams a
// result window back to the host. Every output is registered.
// Optional feature macro: RUN_SEQ_CHECKSUM_EN appends one byte holding the
// 8-bit sum of all loaded bytes and result bytes of the run.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_LEN    = 64,
  parameter int RES_BASE    = 64,
  parameter int RES_LEN     = 4,
  parameter int START_CYC   = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic              InValid,
  input  logic [BYTE_W-1:0] InData,
  output logic              InReady,
  output logic              LdWen,
  output logic [ADDR_W-1:0] LdAddr,
  output logic [BYTE_W-1:0] LdDat,
  input  logic [BYTE_W-1:0] RdDat,
  output logic              Start,
  input  logic              Done,
  output logic              OutValid,
  output logic [BYTE_W-1:0] OutData,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Timeout
);

  localparam int CNT_W = 8;
  localparam int KW    = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] RES_BASE_A  = ADDR_W'(RES_BASE);
  localparam logic [CNT_W-1:0]  LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0]  RES_LAST    = CNT_W'(RES_LEN - 1);
  localparam logic [KW-1:0]     KICK_LAST   = KW'(START_CYC - 1);

  seqState_e         state_q, state_d;
  logic              inReady_q, inReady_d;
  logic              ldWen_q, ldWen_d;
  logic [ADDR_W-1:0] ldAddr_q, ldAddr_d;
  logic [BYTE_W-1:0] ldDat_q, ldDat_d;
  logic [ADDR_W-1:0] ldPtr_q, ldPtr_d;
  logic              start_q, start_d;
  logic              outValid_q, outValid_d;
  logic [BYTE_W-1:0] outData_q, outData_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  loadCnt_q, loadCnt_d;
  logic [CNT_W-1:0]  resCnt_q, resCnt_d;
  logic [KW-1:0]     kickCnt_q, kickCnt_d;
  logic              runFirst_q, runFirst_d;
`ifdef RUN_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              csumPhase_q, csumPhase_d;
`endif

  logic wdClear;
  logic wdEnable;
  logic wdExpired;

  run_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uWatchdog (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (wdClear),
    .Enable (wdEnable),
    .Expired(wdExpired)
  );

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    inReady_d  = inReady_q;
    ldWen_d    = 1'b0;
    ldAddr_d   = ldAddr_q;
    ldDat_d    = ldDat_q;
    ldPtr_d    = ldPtr_q;
    start_d    = start_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    timeout_d  = timeout_q;
    loadCnt_d  = loadCnt_q;
    resCnt_d   = resCnt_q;
    kickCnt_d  = kickCnt_q;
    runFirst_d = 1'b0;
    wdClear    = 1'b0;
    wdEnable   = 1'b0;
`ifdef RUN_SEQ_CHECKSUM_EN
    sum_d       = sum_q;
    csumPhase_d = csumPhase_q;
`endif

    unique case (state_q)
      IDLE: begin
        start_d   = 1'b1;
        inReady_d = 1'b0;
        if (Go) begin
          state_d   = LOAD;
          timeout_d = 1'b0;
          loadCnt_d = '0;
          ldAddr_d  = LOAD_BASE_A;
          ldPtr_d   = LOAD_BASE_A;
          inReady_d = 1'b1;
`ifdef RUN_SEQ_CHECKSUM_EN
          sum_d       = '0;
          csumPhase_d = 1'b0;
`endif
        end
      end

      LOAD: begin
        if (InValid && inReady_q) begin
          ldWen_d   = 1'b1;
          ldAddr_d  = ldPtr_q;
          ldDat_d   = InData;
          ldPtr_d   = addrInc(ldPtr_q);
          loadCnt_d = loadCnt_q + 1'b1;
`ifdef RUN_SEQ_CHECKSUM_EN
          sum_d = sum_q + InData;
`endif
          if (loadCnt_q == LOAD_LAST) begin
            inReady_d = 1'b0;
            kickCnt_d = '0;
            state_d   = KICK;
          end
        end
      end

      KICK: begin
        start_d = 1'b1;
        wdClear = 1'b1;
        if (kickCnt_q == KICK_LAST) begin
          start_d    = 1'b0;
          runFirst_d = 1'b1;
          state_d    = RUN;
        end else begin
          kickCnt_d = kickCnt_q + 1'b1;
        end
      end

      RUN: begin
        wdEnable = 1'b1;
        if (Done && !runFirst_q) begin
          ldAddr_d = RES_BASE_A;
          resCnt_d = '0;
          state_d  = READ;
        end else if (wdExpired) begin
          timeout_d = 1'b1;
          start_d   = 1'b1;
          state_d   = IDLE;
        end
      end

      READ: begin
        outValid_d = 1'b1;
        state_d    = SEND;
`ifdef RUN_SEQ_CHECKSUM_EN
        if (csumPhase_q) begin
          outData_d = sum_q;
        end else begin
          outData_d = RdDat;
          sum_d     = sum_q + RdDat;
        end
`else
        outData_d = RdDat;
`endif
      end

      SEND: begin
        if (outValid_q && OutReady) begin
          outValid_d = 1'b0;
`ifdef RUN_SEQ_CHECKSUM_EN
          if (csumPhase_q) begin
            csumPhase_d = 1'b0;
            start_d     = 1'b1;
            state_d     = IDLE;
          end else if (resCnt_q == RES_LAST) begin
            csumPhase_d = 1'b1;
            state_d     = READ;
          end else begin
            resCnt_d = resCnt_q + 1'b1;
            ldAddr_d = RES_BASE_A + (resCnt_q + 1'b1);
            state_d  = READ;
          end
`else
          if (resCnt_q == RES_LAST) begin
            start_d = 1'b1;
            state_d = IDLE;
          end else begin
            resCnt_d = resCnt_q + 1'b1;
            ldAddr_d = RES_BASE_A + (resCnt_q + 1'b1);
            state_d  = READ;
          end
`endif
        end
      end

      default: begin
        start_d = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any run and holds the core.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b0;
      ldWen_q    <= 1'b0;
      ldAddr_q   <= '0;
      ldDat_q    <= '0;
      ldPtr_q    <= '0;
      start_q    <= 1'b1;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      loadCnt_q  <= '0;
      resCnt_q   <= '0;
      kickCnt_q  <= '0;
      runFirst_q <= 1'b0;
`ifdef RUN_SEQ_CHECKSUM_EN
      sum_q       <= '0;
      csumPhase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inReady_q  <= inReady_d;
      ldWen_q    <= ldWen_d;
      ldAddr_q   <= ldAddr_d;
      ldDat_q    <= ldDat_d;
      ldPtr_q    <= ldPtr_d;
      start_q    <= start_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      loadCnt_q  <= loadCnt_d;
      resCnt_q   <= resCnt_d;
      kickCnt_q  <= kickCnt_d;
      runFirst_q <= runFirst_d;
`ifdef RUN_SEQ_CHECKSUM_EN
      sum_q       <= sum_d;
      csumPhase_q <= csumPhase_d;
`endif
    end
  end

  assign InReady  = inReady_q;
  assign LdWen    = ldWen_q;
  assign LdAddr   = ldAddr_q;
  assign LdDat    = ldDat_q;
  assign Start    = start_q;
  assign OutValid = outValid_q;
  assign OutData  = outData_q;
  assign Busy     = busy_q;
  assign Timeout  = timeout_q;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Host-side front end that sits directly upstream of the CPU top level, which has Start/Done and a data-memory write port.
- Accepts a byte stream from the host and writes it into data memory as the operand image.
- Then pulses Start, waits for Done (with a watchdog), reads a result window back out of data memory and streams it to the host.
- Owns every Start assertion the core sees; the core is held idle otherwise.

Parameters:
- LOAD_BASE, 0, first DMem address written by the load phase
- LOAD_LEN, 64, number of bytes loaded per run (1..256)
- RES_BASE, 64, first DMem address of the result window
- RES_LEN, 4, number of result bytes streamed out (1..256)
- START_CYC, 2, cycles Start is held high before release (>=1)
- TIMEOUT_CYC, 1000000, max cycles in RUN before abort; counter width $clog2(TIMEOUT_CYC+1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Go  in  1  host request to begin a run; sampled only in IDLE
- InValid  in  1  host load byte valid
- InData  in  8  host load byte
- InReady  out  1  sequencer accepts InData this cycle
- LdWen  out  1  DMem write enable (muxed ahead of core write port)
- LdAddr  out  8  DMem write/read address during LOAD/READ
- LdDat  out  8  DMem write data
- RdDat  in  8  DMem read data; combinational from LdAddr
- Start  out  1  core start/hold
- Done  in  1  core done
- OutValid  out  1  result byte valid
- OutData  out  8  result byte
- OutReady  in  1  host accepts OutData
- Busy  out  1  high in any state other than IDLE
- Timeout  out  1  sticky; set when the watchdog expires, cleared on next Go

Behaviour:
- All outputs are registered. Reset values: InReady=0, LdWen=0, LdAddr=0, LdDat=0, Start=1 (core held), OutValid=0, OutData=0, Busy=0, Timeout=0; state=IDLE, all counters 0.
- Reset at any point aborts the run immediately, with no partial stream completion.
- FSM states: IDLE, LOAD, KICK, RUN, READ, SEND.
- IDLE: Start=1. When Go=1, move to LOAD, clear Timeout and load counter, set LdAddr=LOAD_BASE.
- LOAD:
  - InReady=1. Each InValid&InReady handshake produces LdWen=1 with LdAddr/LdDat on the next cycle, then LdAddr increments.
  - Address arithmetic is 8-bit and wraps 255->0.
  - After LOAD_LEN handshakes (counter==LOAD_LEN-1 at handshake), InReady drops in the same cycle the last byte registers, and the FSM moves to KICK.
  - No backpressure timeout applies in LOAD.
- KICK: Start=1 for START_CYC cycles, then Start=0 and move to RUN; the watchdog is cleared on entry to RUN.
- RUN:
  - Start=0. If Done=1 while Start=0, go to READ.
  - A Done already high on the first RUN cycle is ignored, because the core is still deasserting from the hold.
  - If the watchdog reaches TIMEOUT_CYC, set Timeout=1, assert Start=1 and return to IDLE (no result stream).
- READ/SEND:
  - LdAddr=RES_BASE+i. One cycle later RdDat is captured into OutData and OutValid=1.
  - OutValid/OutData stay stable until OutReady; after the handshake, i increments.
  - After RES_LEN handshakes, Start=1 and go to IDLE.
  - At most one result byte per two cycles.
- Go outside IDLE is ignored.
- Done in any state other than RUN is ignored.
- LdWen is never high outside LOAD.

Optional Feature:
- Macro: RUN_SEQ_CHECKSUM_EN.
- Defined: after the RES_LEN result bytes, one extra byte is sent, equal to the 8-bit modular sum of all LOAD bytes and result bytes of this run. It uses the same handshake.
- Undefined: exactly RES_LEN bytes are sent; no accumulator logic is present.

Decomposition:
- Shared package run_seq_pkg holds:
  - the state enum (IDLE..SEND, 3-bit),
  - the byte width constant (8),
  - the DMem address width constant (8).
- One natural sub-module: run_watchdog (load-clear, enable, terminal-count flag, parameterised by TIMEOUT_CYC).

Test Plan:
1. Reset, then Go with LOAD_LEN=4, bytes 11,22,33,44 at 1/cycle -> LdWen pulses at addr 0..3 with those data; InReady low after the 4th; Start high 2 cycles, then low.
2. Load with InValid gaps and Done pulsed 10 cycles into RUN, with DMem[64..67]=A0,A1,A2,A3 -> OutData streams A0..A3; Busy falls and Start=1 after the last handshake.
3. OutReady held low 5 cycles on the second result byte -> OutValid/OutData stay at A1, unchanged, until accepted.
4. TIMEOUT_CYC=20, Done never asserted -> Timeout=1 on cycle 20 of RUN, Start=1, IDLE, no OutValid; the next Go clears Timeout.
5. Reset asserted mid-LOAD after 2 bytes -> next cycle all outputs at reset values; a fresh Go restarts at LOAD_BASE.
6. LOAD_BASE=254, LOAD_LEN=4 -> writes at 254,255,0,1. With RUN_SEQ_CHECKSUM_EN, bytes 1,2,3,4 and results 5,6,7,8 give a 5th output byte of 0x24.
